// File: rtl/front_panel_enc_reader.sv
// Polls the front-panel rotary-encoder event register, strobes its read/clear line and turns events into a
// saturating volume and a mute toggle. Optional click acceleration is compiled in with ENC_READER_ACCEL_EN.
module front_panel_enc_reader #(
  parameter int VOL_WIDTH    = 8,
  parameter int VOL_MAX      = 255,
  parameter int VOL_DEFAULT  = 128,
  parameter int STEP         = 1,
  parameter int ACCEL_WINDOW = 4800,
  parameter int ACCEL_STEP   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rotary_encoder_reg,
  output logic                 rotary_encoder_rd_stb,
  output logic [VOL_WIDTH-1:0] volume,
  output logic                 mute,
  output logic                 vol_change_stb,
  output logic                 mute_change_stb,
  output logic                 busy
);

  localparam int VW1 = VOL_WIDTH + 1;
  localparam logic [VOL_WIDTH:0]   VMAX_W = VW1'(VOL_MAX);
  localparam logic [VOL_WIDTH:0]   STEP_W = VW1'(STEP);
  localparam logic [VOL_WIDTH-1:0] VDEF_W = VOL_WIDTH'(VOL_DEFAULT);

  typedef enum logic [1:0] {IDLE, READ, GUARD, APPLY} state_t;

  state_t               state_q, state_d;
  logic                 rd_stb_q, rd_stb_d;
  logic                 click_q, click_d;
  logic                 cw_q, cw_d;
  logic                 sw_q, sw_d;
  logic                 sw_prev_q, sw_prev_d;
  logic [VOL_WIDTH-1:0] vol_q, vol_d;
  logic                 mute_q, mute_d;
  logic                 vol_stb_q, vol_stb_d;
  logic                 mute_stb_q, mute_stb_d;
  logic                 busy_q, busy_d;

  logic [VOL_WIDTH:0]   step_w;
  logic [VOL_WIDTH:0]   sum_w;
  logic [VOL_WIDTH:0]   diff_w;
  logic [VOL_WIDTH-1:0] vol_next;

  // Upper register bits carry no information.
  logic unused_hi;
  assign unused_hi = ^rotary_encoder_reg[7:4];

`ifdef ENC_READER_ACCEL_EN
  localparam int CW = VOL_WIDTH + 16;
  localparam logic [CW-1:0]        WIN_W   = CW'(ACCEL_WINDOW);
  localparam logic [VOL_WIDTH:0]   ACCEL_W = VW1'(ACCEL_STEP);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_dir_q, last_dir_d;

  always_comb begin
    cnt_d      = cnt_q;
    last_dir_d = last_dir_q;
    if (state_q == GUARD && click_q) begin
      cnt_d      = '0;
      last_dir_d = cw_q;
    end else if (cnt_q < WIN_W) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= WIN_W;
      last_dir_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      last_dir_q <= last_dir_d;
    end
  end

  assign step_w = (cw_q == last_dir_q && cnt_q < WIN_W) ? ACCEL_W : STEP_W;
`else
  localparam int unused_accel = ACCEL_WINDOW + ACCEL_STEP;
  assign step_w = STEP_W;
`endif

  // Extra bit keeps the sum and difference from wrapping before saturation.
  assign sum_w  = {1'b0, vol_q} + step_w;
  assign diff_w = {1'b0, vol_q} - step_w;

  always_comb begin
    vol_next = vol_q;
    if (click_q) begin
      if (cw_q) vol_next = (sum_w > VMAX_W) ? VMAX_W[VOL_WIDTH-1:0] : sum_w[VOL_WIDTH-1:0];
      else      vol_next = diff_w[VOL_WIDTH] ? '0 : diff_w[VOL_WIDTH-1:0];
    end
  end

  // Results are registered on the GUARD->APPLY edge so they are visible during APPLY.
  always_comb begin
    state_d    = state_q;
    rd_stb_d   = 1'b0;
    click_d    = click_q;
    cw_d       = cw_q;
    sw_d       = sw_q;
    sw_prev_d  = sw_prev_q;
    vol_d      = vol_q;
    mute_d     = mute_q;
    vol_stb_d  = 1'b0;
    mute_stb_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rotary_encoder_reg[3]) begin
          state_d  = READ;
          rd_stb_d = 1'b1;
        end
      end
      READ: begin
        click_d = rotary_encoder_reg[0];
        cw_d    = rotary_encoder_reg[1];
        sw_d    = rotary_encoder_reg[2];
        state_d = GUARD;
      end
      GUARD: begin
        state_d   = APPLY;
        vol_d     = vol_next;
        vol_stb_d = (vol_next != vol_q);
        if (sw_q && !sw_prev_q) begin
          mute_d     = ~mute_q;
          mute_stb_d = 1'b1;
        end
        sw_prev_d = sw_q;
      end
      APPLY: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_stb_q   <= 1'b0;
      click_q    <= 1'b0;
      cw_q       <= 1'b0;
      sw_q       <= 1'b0;
      sw_prev_q  <= 1'b0;
      vol_q      <= VDEF_W;
      mute_q     <= 1'b0;
      vol_stb_q  <= 1'b0;
      mute_stb_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_stb_q   <= rd_stb_d;
      click_q    <= click_d;
      cw_q       <= cw_d;
      sw_q       <= sw_d;
      sw_prev_q  <= sw_prev_d;
      vol_q      <= vol_d;
      mute_q     <= mute_d;
      vol_stb_q  <= vol_stb_d;
      mute_stb_q <= mute_stb_d;
      busy_q     <= busy_d;
    end
  end

  assign rotary_encoder_rd_stb = rd_stb_q;
  assign volume                = vol_q;
  assign mute                  = mute_q;
  assign vol_change_stb        = vol_stb_q;
  assign mute_change_stb       = mute_stb_q;
  assign busy                  = busy_q;

endmodule

// File: tb/tb_front_panel_enc_reader.sv
// Scoreboard bench for front_panel_enc_reader: a register model serves events, a monitor checks each APPLY cycle.
module tb_front_panel_enc_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] enc_reg;
  logic       rd_stb;
  logic [7:0] volume;
  logic       mute, vstb, mstb, busy;

  always #5 clk = ~clk;

  front_panel_enc_reader dut (
    .clk                  (clk),
    .reset                (reset),
    .rotary_encoder_reg   (enc_reg),
    .rotary_encoder_rd_stb(rd_stb),
    .volume               (volume),
    .mute                 (mute),
    .vol_change_stb       (vstb),
    .mute_change_stb      (mstb),
    .busy                 (busy)
  );

  typedef struct {int vol; int mute; int vstb; int mstb;} exp_t;
  exp_t exp_q[$];

  int total = 0, bad = 0;
  int applied = 0, rd_cnt = 0, exp_rd = 0, cyc = 0, mon_run = 0;

  int m_vol = 128, m_mute = 0, m_swprev = 0, m_has_last = 0, m_last_dir = 0, m_last_cyc = 0;

  bit         post_req = 1'b0;
  logic [7:0] ev_next = 8'h00;
  logic       stb_s;

  function automatic void check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Encoder register model: a new event (set) wins over the read/clear strobe.
  initial begin
    enc_reg = 8'h00;
    forever begin
      @(negedge clk);
      stb_s = rd_stb;
      @(posedge clk);
      #1;
      if (post_req) begin
        enc_reg  = ev_next;
        post_req = 1'b0;
      end else if (stb_s) begin
        enc_reg[3] = 1'b0;
      end
    end
  end

  // Monitor: the third busy cycle is APPLY; compare it against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_run = 0;
      end else if (busy) begin
        mon_run++;
        if (rd_stb) rd_cnt++;
        check("rd_stb_pos", int'(rd_stb), int'(mon_run == 1));
        if (mon_run == 3) begin
          check("apply_expected", exp_q.size() > 0 ? 1 : 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("volume", int'(volume), e.vol);
            check("mute", int'(mute), e.mute);
            check("vol_change_stb", int'(vstb), e.vstb);
            check("mute_change_stb", int'(mstb), e.mstb);
            $display("apply #%0d: volume=%0d mute=%0d vstb=%0d mstb=%0d", applied, volume, mute, vstb, mstb);
          end
          applied++;
        end else begin
          check("stb_outside_apply", int'({vstb, mstb}), 0);
        end
      end else begin
        if (mon_run != 0) check("busy_len", mon_run, 3);
        mon_run = 0;
        check("idle_strobes", int'({rd_stb, vstb, mstb}), 0);
      end
    end
  end

  function automatic exp_t model(logic [7:0] ev);
    exp_t e;
    int   step = 1;
    int   old  = m_vol;
`ifdef ENC_READER_ACCEL_EN
    if (ev[0]) begin
      if (m_has_last != 0 && int'(ev[1]) == m_last_dir && (cyc - m_last_cyc) < 4800) step = 4;
      m_has_last = 1;
      m_last_dir = int'(ev[1]);
      m_last_cyc = cyc;
    end
`endif
    if (ev[0]) begin
      if (ev[1]) m_vol = (old + step > 255) ? 255 : old + step;
      else       m_vol = (old - step < 0) ? 0 : old - step;
    end
    e.vstb = (m_vol != old) ? 1 : 0;
    e.mstb = 0;
    if (ev[2] && m_swprev == 0) begin
      m_mute = 1 - m_mute;
      e.mstb = 1;
    end
    m_swprev = int'(ev[2]);
    e.vol  = m_vol;
    e.mute = m_mute;
    return e;
  endfunction

  task automatic post(input logic [7:0] ev);
    exp_q.push_back(model(ev));
    ev_next  = ev;
    post_req = 1'b1;
    exp_rd++;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (applied < target && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("event_done", applied, target);
  endtask

  task automatic event1(input logic [7:0] ev);
    int t = applied + 1;
    post(ev);
    wait_done(t);
  endtask

  task automatic model_reset();
    m_vol = 128; m_mute = 0; m_swprev = 0; m_has_last = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    int n;
    int t;
    reset = 1'b1;
    #1;
    check("rst_volume", int'(volume), 128);
    check("rst_mute", int'(mute), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rd_stb", int'(rd_stb), 0);
    check("rst_vstb", int'(vstb), 0);
    check("rst_mstb", int'(mstb), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single cw click, then drive volume up to the top limit and beyond.
    event1(8'h0B);
    for (int i = 0; i < 130; i++) event1(8'h0B);
    check("vol_at_max", int'(volume), 255);
    event1(8'h0B);

    // Down to zero and one more ccw click at the bottom.
    for (int i = 0; i < 260; i++) event1(8'h09);
    check("vol_at_min", int'(volume), 0);
    event1(8'h09);

    // Switch press, release, press.
    event1(8'h0C);
    event1(8'h08);
    event1(8'h0C);
    check("mute_after_switches", int'(mute), 0);

    // New event set on the same cycle as the read strobe.
    t = applied + 2;
    post(8'h0B);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd_stb && n < 20);
    check("rd_stb_seen", int'(rd_stb), 1);
    post(8'h0B);
    wait_done(t);
    repeat (10) @(negedge clk);

    // Reset during GUARD; the event is still pending after release.
    post(8'h0B);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (mon_run != 2 && n < 20);
    check("reached_guard", mon_run, 2);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_volume", int'(volume), 128);
    check("midrst_mute", int'(mute), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_strobes", int'({rd_stb, vstb, mstb}), 0);
    exp_q.delete(0);
    model_reset();
    t = applied + 1;
    post(8'h0B);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_done(t);
    check("vol_after_reread", int'(volume), 129);
    repeat (10) @(negedge clk);

`ifdef ENC_READER_ACCEL_EN
    do_reset();
    event1(8'h0B);
    repeat (100) @(negedge clk);
    event1(8'h0B);
    check("accel_close", int'(volume), 133);
    do_reset();
    event1(8'h0B);
    repeat (5000) @(negedge clk);
    event1(8'h0B);
    check("accel_far", int'(volume), 130);
`endif

    repeat (5) @(negedge clk);
    check("rd_stb_count", rd_cnt, exp_rd);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
